// File: rtl/adc_share_arbiter_pkg.sv
// tsc_pkg: shared state encoding and sizing constants for the ADC share arbiter
package tsc_pkg;
   localparam int NUM_CLIENTS = 4;
   localparam int ADC_DATA_W  = 8;
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, GAP = 2'd3} state_t;
endpackage

// File: rtl/adc_share_arbiter_if.sv
// adc_share_arbiter_if: client request/ack bus plus ADC pin handshake
interface adc_share_arbiter_if
   import tsc_pkg::*;
#(
   parameter int N_CLIENTS = NUM_CLIENTS,
   parameter int DATA_W    = ADC_DATA_W
);
   logic [N_CLIENTS-1:0] cli_req, cli_ack, cli_err;
   logic [DATA_W-1:0]    cli_dat, adc_dat;
   logic                 adc_req, adc_rdy, busy;
   modport master (output cli_req, adc_rdy, adc_dat, input cli_ack, cli_dat, cli_err, adc_req, busy);
   modport slave  (input cli_req, adc_rdy, adc_dat, output cli_ack, cli_dat, cli_err, adc_req, busy);
endinterface

// File: rtl/adc_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick of the first request at/after ptr, wrapping
module rr_pick #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          valid
);
   logic [IW-1:0] j;
   always_comb begin
      idx = '0;
      j = '0;
      for (int i = N - 1; i >= 0; i--) begin
         j = IW'((int'(ptr) + i) % N);
         idx = req[j] ? j : idx;
      end
   end
   assign valid = |req;
   assign gnt = valid ? N'(1) << idx : '0;
endmodule

// File: rtl/adc_share_arbiter.sv
// adc_share_arbiter: round-robin sharing of one ADC among capture clients; define ADC_TIMEOUT_EN to abort stuck conversions
module adc_share_arbiter
   import tsc_pkg::*;
#(
   parameter int N_CLIENTS   = NUM_CLIENTS,
   parameter int DATA_W      = ADC_DATA_W,
   parameter int GAP_CYC     = 1,
   parameter int TIMEOUT_CYC = 255
) (
   input logic clk,
   input logic reset,
   adc_share_arbiter_if.slave bus
);
   localparam int IW      = $clog2(N_CLIENTS);
   localparam int CNT_MAX = GAP_CYC > TIMEOUT_CYC ? GAP_CYC : TIMEOUT_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1) < 8 ? 8 : $clog2(CNT_MAX + 1);
   state_t state, state_n;
   logic [IW-1:0] rr_ptr, grant_id, pick_idx;
   logic [N_CLIENTS-1:0] pick_gnt, grant_oh;
   logic pick_v, tmo;
   logic [CNT_W-1:0] cnt;
   logic [DATA_W-1:0] dat_q;
   rr_pick #(.N(N_CLIENTS)) u_pick (
      .req(bus.cli_req),
      .ptr(rr_ptr),
      .gnt(pick_gnt),
      .idx(pick_idx),
      .valid(pick_v)
   );
`ifdef ADC_TIMEOUT_EN
   logic err_q;
   assign tmo = state == REQ && !bus.adc_rdy && int'(cnt) == TIMEOUT_CYC - 1;
   always_ff @(posedge clk or posedge reset)
      if (reset) err_q <= 1'b0;
      else err_q <= tmo;
   assign bus.cli_err = err_q ? grant_oh : '0;
`else
   assign tmo = 1'b0;
   assign bus.cli_err = '0;
`endif
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = pick_v ? REQ : IDLE;
         REQ:     state_n = bus.adc_rdy ? DONE : (tmo ? GAP : REQ);
         DONE:    state_n = GAP;
         GAP:     state_n = (int'(cnt) + 1 >= GAP_CYC && !bus.adc_rdy) ? IDLE : GAP;
         default: state_n = IDLE;
      endcase
   end
   // cnt restarts on every state change; it times the gap and, optionally, the REQ wait
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         grant_oh <= '0;
         dat_q    <= '0;
         cnt      <= '0;
      end else begin
         state <= state_n;
         cnt   <= (state_n != state) ? '0 : (&cnt ? cnt : cnt + 1'b1);
         if (state == IDLE && pick_v) begin
            grant_id <= pick_idx;
            grant_oh <= pick_gnt;
         end
         if (state == REQ && bus.adc_rdy) dat_q <= bus.adc_dat;
         if (state == DONE || tmo) rr_ptr <= (grant_id == IW'(N_CLIENTS - 1)) ? '0 : grant_id + 1'b1;
      end
   assign bus.adc_req = state == REQ;
   assign bus.busy    = state != IDLE;
   assign bus.cli_ack = state == DONE ? grant_oh : '0;
   assign bus.cli_dat = dat_q;
endmodule

// File: tb/tb_adc_share_arbiter.sv
// tb_adc_share_arbiter: directed scoreboard bench for the round-robin ADC share arbiter
module tb_adc_share_arbiter;
   logic clk = 1'b0;
   logic reset;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int mptr = 0;
   logic [11:0] sb[$];
   logic [11:0] exp_e;
   adc_share_arbiter_if bus ();
   adc_share_arbiter #(.GAP_CYC(1), .TIMEOUT_CYC(10)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic int model_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
      return 0;
   endfunction
   always @(negedge clk)
      if (!reset && bus.cli_ack !== 4'b0) begin
         if (sb.size() == 0) chk("ack_unexpected", bus.cli_ack, 0);
         else begin
            exp_e = sb.pop_front();
            chk("sb_ack", bus.cli_ack, exp_e[11:8]);
            chk("sb_dat", bus.cli_dat, exp_e[7:0]);
         end
      end
   task automatic wait_req();
      int w = 0;
      while (bus.adc_req !== 1'b1 && w < 50) begin @(negedge clk); w++; end
      chk("req_wait", bus.adc_req, 1);
   endtask
   task automatic serve(input int dly, input logic [7:0] d, input bit drop, input int hold, output int t_ack);
      int win;
      logic [3:0] mask;
      wait_req();
      win = model_pick(bus.cli_req, mptr);
      mask = 4'(1 << win);
      repeat (dly) @(negedge clk);
      bus.adc_dat = d;
      bus.adc_rdy = 1'b1;
      sb.push_back({mask, d});
      @(negedge clk);
      t_ack = cyc;
      chk("ack_lat", bus.cli_ack, mask);
      if (drop) bus.cli_req[win] = 1'b0;
      for (int i = 0; i < hold; i++) begin
         chk("hold_req", bus.adc_req, 0);
         chk("hold_busy", bus.busy, 1);
         @(negedge clk);
      end
      bus.adc_rdy = 1'b0;
      mptr = (win + 1) % 4;
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      int t, t_prev, n, win;
      reset = 1'b1;
      bus.cli_req = '0;
      bus.adc_rdy = 1'b0;
      bus.adc_dat = '0;
      repeat (3) @(negedge clk);
      chk("rst_adc_req", bus.adc_req, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ack", bus.cli_ack, 0);
      chk("rst_err", bus.cli_err, 0);
      chk("rst_dat", bus.cli_dat, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy", bus.busy, 0);
      // single client, ADC answers two cycles after the request
      bus.cli_req = 4'b0010;
      @(negedge clk);
      chk("req_latency", bus.adc_req, 1);
      serve(2, 8'hD6, 1'b1, 0, t);
      @(negedge clk);
      chk("ack_pulse", bus.cli_ack, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mptr = 0;
      // all clients held, immediate ADC: strict rotation at the minimum period
      bus.cli_req = 4'hF;
      t_prev = 0;
      for (int k = 0; k < 8; k++) begin
         serve(0, 8'h10 + 8'(k), 1'b0, 0, t);
         if (k > 0) chk("ack_period", t - t_prev, 4);
         t_prev = t;
      end
      bus.cli_req = '0;
      repeat (4) @(negedge clk);
      // move pointer to 3, then requests on 3 and 0 must wrap
      bus.cli_req = 4'b0100;
      serve(0, 8'h21, 1'b1, 0, t);
      bus.cli_req = 4'b1001;
      serve(0, 8'h33, 1'b1, 0, t);
      serve(1, 8'h44, 1'b1, 0, t);
      repeat (3) @(negedge clk);
      // reset during REQ aborts silently and restarts the rotation at 0
      bus.cli_req = 4'b0100;
      wait_req();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_async_req", bus.adc_req, 0);
      chk("rst_async_busy", bus.busy, 0);
      @(negedge clk);
      @(negedge clk);
      bus.cli_req = 4'b0101;
      mptr = 0;
      reset = 1'b0;
      serve(0, 8'h55, 1'b1, 0, t);
      serve(0, 8'h66, 1'b1, 0, t);
      repeat (3) @(negedge clk);
`ifdef ADC_TIMEOUT_EN
      bus.cli_req = 4'b0011;
      wait_req();
      win = model_pick(bus.cli_req, mptr);
      n = 0;
      while (bus.cli_err === 4'b0 && n < 40) begin @(negedge clk); n++; end
      chk("tmo_cycles", n, 10);
      chk("tmo_err", bus.cli_err, 4'(1 << win));
      chk("tmo_noack", bus.cli_ack, 0);
      chk("tmo_req_low", bus.adc_req, 0);
      bus.cli_req[win] = 1'b0;
      mptr = (win + 1) % 4;
      @(negedge clk);
      chk("tmo_pulse", bus.cli_err, 0);
      serve(0, 8'h77, 1'b1, 0, t);
`else
      chk("err_tied", bus.cli_err, 0);
`endif
      repeat (3) @(negedge clk);
      // adc_rdy lingering after capture stretches the gap, no second ack
      bus.cli_req = 4'b1010;
      serve(1, 8'h5A, 1'b1, 3, t);
      serve(0, 8'h3C, 1'b1, 0, t);
      repeat (5) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      chk("end_busy", bus.busy, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
